// File: rtl/weight_memory_arbiter_pkg.sv
// Shared types for the weight memory arbiter: power-state encoding and the
// requester ids tracked by the round-robin pointer.
package weight_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } pwr_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_LD = 1'b0;
  localparam req_id_t REQ_RD = 1'b1;

endpackage

// File: rtl/weight_memory_power_fsm.sv
// Power sequencing for the weight memory: idle detection, sleep, and a fixed
// wake-up delay before requests are served again.
module weight_memory_power_fsm
  import weight_memory_arbiter_pkg::*;
#(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic any_req_i,
  input  logic sleep_en_i,
  output logic active_o,
  output logic power_down_o,
  output logic asleep_o
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  pwr_state_e    state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [WW-1:0] wake_q, wake_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACTIVE;
      idle_q  <= '0;
      wake_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
    end
  end

  // Counters clear whenever their state is left or the idle streak breaks.
  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    wake_d  = '0;
    case (state_q)
      ST_ACTIVE: begin
        if (!any_req_i && sleep_en_i) begin
          if (idle_q == IDLE_LAST) state_d = ST_SLEEP;
          else                     idle_d  = idle_q + 1'b1;
        end
      end
      ST_SLEEP: begin
        if (any_req_i || !sleep_en_i) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (wake_q == WAKE_LAST) state_d = ST_ACTIVE;
        else                     wake_d  = wake_q + 1'b1;
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_comb begin
    active_o     = (state_q == ST_ACTIVE);
    power_down_o = (state_q == ST_SLEEP);
    asleep_o     = (state_q == ST_SLEEP);
  end

endmodule

// File: rtl/weight_memory_arbiter.sv
// Shares the single weight-SRAM port between loader writes and compute reads,
// with round-robin on contention, power-down sequencing and safe mode updates.
module weight_memory_arbiter
  import weight_memory_arbiter_pkg::*;
#(
  parameter int WIDTH       = 1024,
  parameter int NUM_ROWS    = 128,
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 2,
  localparam int AW         = $clog2(NUM_ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [WIDTH-1:0] ld_mask,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [AW-1:0]    rd_addr,
  output logic             rd_data_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             cfg_4x4_mode,
  input  logic             cfg_sleep_en,
  output logic             asleep,
  output logic [AW-1:0]    mem_address,
  output logic [WIDTH-1:0] mem_data_in,
  output logic [WIDTH-1:0] mem_mask,
  output logic             mem_chip_select,
  output logic             mem_write_enable,
  output logic             mem_power_down,
  output logic             mem_in_4x4_mode,
  input  logic [WIDTH-1:0] mem_data_out
);

  logic    active;
  logic    ld_acc, rd_acc, any_acc;
  req_id_t rr_last_q, rr_last_d;
  logic    rd_vld_q;
  logic    mode_q;

  weight_memory_power_fsm #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .WAKE_CYCLES (WAKE_CYCLES)
  ) u_power_fsm (
    .clk          (clk),
    .rst          (rst),
    .any_req_i    (ld_valid | rd_valid),
    .sleep_en_i   (cfg_sleep_en),
    .active_o     (active),
    .power_down_o (mem_power_down),
    .asleep_o     (asleep)
  );

  // On a tie the requester that was not granted last wins.
  always_comb begin
    ld_ready  = active & ld_valid & (~rd_valid | (rr_last_q == REQ_RD));
    rd_ready  = active & rd_valid & (~ld_valid | (rr_last_q == REQ_LD));
    ld_acc    = ld_valid & ld_ready;
    rd_acc    = rd_valid & rd_ready;
    any_acc   = ld_acc | rd_acc;
    rr_last_d = rr_last_q;
    if (ld_acc)      rr_last_d = REQ_LD;
    else if (rd_acc) rr_last_d = REQ_RD;
  end

  always_comb begin
    mem_chip_select  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_data_in      = '0;
    mem_mask         = '0;
    if (ld_acc) begin
      mem_chip_select  = 1'b1;
      mem_write_enable = 1'b1;
      mem_address      = ld_addr;
      mem_data_in      = ld_data;
      mem_mask         = ld_mask;
    end else if (rd_acc) begin
      mem_chip_select  = 1'b1;
      mem_address      = rd_addr;
    end
  end

  // Mode only moves on non-accept edges, so a read's request and response
  // cycles always see the same mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= REQ_LD;
      rd_vld_q  <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      rr_last_q <= rr_last_d;
      rd_vld_q  <= rd_acc;
      if (!any_acc) mode_q <= cfg_4x4_mode;
    end
  end

  // A response still pending when reset arrives is suppressed.
  assign rd_data_valid   = rd_vld_q & ~rst;
  assign rd_data         = mem_data_out;
  assign mem_in_4x4_mode = mode_q;

endmodule

// File: tb/tb_weight_memory_arbiter.sv
// Directed bench for weight_memory_arbiter: read data is scoreboarded through
// a queue filled by the stimulus and drained by an independent monitor.
module tb_weight_memory_arbiter;

  localparam int WIDTH       = 32;
  localparam int NUM_ROWS    = 16;
  localparam int AW          = 4;
  localparam int IDLE_CYCLES = 64;
  localparam int WAKE_CYCLES = 2;
  localparam int TMO         = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_valid, ld_ready;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data, ld_mask;
  logic             rd_valid, rd_ready;
  logic [AW-1:0]    rd_addr;
  logic             rd_data_valid;
  logic [WIDTH-1:0] rd_data;
  logic             cfg_4x4_mode, cfg_sleep_en, asleep;
  logic [AW-1:0]    mem_address;
  logic [WIDTH-1:0] mem_data_in, mem_mask;
  logic             mem_chip_select, mem_write_enable, mem_power_down, mem_in_4x4_mode;
  logic [WIDTH-1:0] mem_data_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] sram [NUM_ROWS];

  always #5 clk = ~clk;

  weight_memory_arbiter #(
    .WIDTH(WIDTH), .NUM_ROWS(NUM_ROWS),
    .IDLE_CYCLES(IDLE_CYCLES), .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_mask(ld_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .cfg_4x4_mode(cfg_4x4_mode), .cfg_sleep_en(cfg_sleep_en), .asleep(asleep),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_mask(mem_mask),
    .mem_chip_select(mem_chip_select), .mem_write_enable(mem_write_enable),
    .mem_power_down(mem_power_down), .mem_in_4x4_mode(mem_in_4x4_mode),
    .mem_data_out(mem_data_out)
  );

  // Behavioural SRAM: masked write, registered one-cycle read.
  always @(posedge clk) begin
    if (mem_chip_select && mem_write_enable)
      sram[mem_address] <= (sram[mem_address] & ~mem_mask) | (mem_data_in & mem_mask);
    if (mem_chip_select && !mem_write_enable)
      mem_data_out <= sram[mem_address];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no accept expected accept within %0d cycles", nm, TMO);
  endtask

  // Monitor: every response must match the oldest expected row.
  always @(negedge clk) begin
    if (!rst && rd_data_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected: got response %0h expected none", rd_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_errors++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] m);
    bit got = 0;
    ld_valid = 1'b1; ld_addr = a; ld_data = d; ld_mask = m;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (ld_ready) begin got = 1; break; end
      tick();
    end
    if (!got) timeout("wr_accept");
    else begin
      chk("wr_cs", mem_chip_select, 1);
      chk("wr_we", mem_write_enable, 1);
      chk("wr_addr", mem_address, a);
      chk("wr_mask", mem_mask, m);
    end
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [WIDTH-1:0] e);
    bit got = 0;
    rd_valid = 1'b1; rd_addr = a;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (rd_ready) begin got = 1; break; end
      tick();
    end
    if (!got) timeout("rd_accept");
    else begin
      chk("rd_cs", mem_chip_select, 1);
      chk("rd_we", mem_write_enable, 0);
      chk("rd_addr", mem_address, a);
      chk("rd_mask", mem_mask, 0);
      exp_q.push_back(e);
    end
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic go_to_sleep();
    bit early = 0;
    cfg_sleep_en = 1'b1;
    for (int i = 0; i < IDLE_CYCLES; i++) begin
      @(negedge clk);
      if (mem_power_down) early = 1;
      tick();
    end
    chk("pd_early", early, 0);
    @(negedge clk);
    chk("pd_rise", mem_power_down, 1);
    chk("asleep_rise", asleep, 1);
    tick();
  endtask

  initial begin
    for (int i = 0; i < NUM_ROWS; i++) sram[i] = '0;
    rst = 1'b1; ld_valid = 0; rd_valid = 0; ld_addr = 0; rd_addr = 0;
    ld_data = 0; ld_mask = 0; cfg_4x4_mode = 0; cfg_sleep_en = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_pd", mem_power_down, 0);
    chk("rst_asleep", asleep, 0);
    chk("rst_mode", mem_in_4x4_mode, 0);
    chk("rst_rdv", rd_data_valid, 0);
    chk("rst_cs", mem_chip_select, 0);
    tick();

    // Single write/read, then a masked write and readback
    do_write(4'd5, 32'hA5A5_1234, 32'hFFFF_FFFF);
    do_write(4'd3, 32'h3333_3333, 32'hFFFF_FFFF);
    do_read(4'd5, 32'hA5A5_1234);
    @(negedge clk);
    chk("idle_cs", mem_chip_select, 0);
    tick();
    do_write(4'd5, 32'hFFFF_FF5A, 32'h0000_00FF);
    do_read(4'd5, 32'hA5A5_125A);
    tick();

    // Contention after reset: RD, LD, RD, LD
    rst = 1'b1; tick(); rst = 1'b0;
    ld_valid = 1; ld_addr = 4'd9; ld_data = 32'h9999_9999; ld_mask = 32'hFFFF_FFFF;
    rd_valid = 1; rd_addr = 4'd3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("rr_rd_ready_c%0d", c), rd_ready, (c % 2) == 1);
      chk($sformatf("rr_ld_ready_c%0d", c), ld_ready, (c % 2) == 0);
      chk($sformatf("rr_rdv_c%0d", c), rd_data_valid, (c % 2) == 0);
      if (rd_ready) exp_q.push_back(32'h3333_3333);
      tick();
    end
    ld_valid = 0; rd_valid = 0;
    @(negedge clk);
    chk("rr_rdv_c5", rd_data_valid, 0);
    tick();

    // Mode change during a read accept is deferred
    rd_valid = 1; rd_addr = 4'd3; cfg_4x4_mode = 1;
    @(negedge clk);
    chk("mode_acc_ready", rd_ready, 1);
    chk("mode_acc_cycle", mem_in_4x4_mode, 0);
    if (rd_ready) exp_q.push_back(32'h3333_3333);
    tick();
    rd_valid = 0;
    @(negedge clk);
    chk("mode_resp_cycle", mem_in_4x4_mode, 0);
    chk("mode_resp_rdv", rd_data_valid, 1);
    tick();
    @(negedge clk);
    chk("mode_after", mem_in_4x4_mode, 1);
    tick();
    cfg_4x4_mode = 0;
    tick();
    @(negedge clk);
    chk("mode_idle_change", mem_in_4x4_mode, 0);
    tick();

    // Sleep, then a read wakes the memory
    go_to_sleep();
    rd_valid = 1; rd_addr = 4'd5;
    @(negedge clk);
    chk("sleep_rd_ready", rd_ready, 0);
    chk("sleep_pd", mem_power_down, 1);
    tick();
    for (int w = 0; w < WAKE_CYCLES; w++) begin
      @(negedge clk);
      chk($sformatf("wake_pd_%0d", w), mem_power_down, 0);
      chk($sformatf("wake_rd_ready_%0d", w), rd_ready, 0);
      tick();
    end
    @(negedge clk);
    chk("wake_accept", rd_ready, 1);
    if (rd_ready) exp_q.push_back(32'hA5A5_125A);
    tick();
    rd_valid = 0; cfg_sleep_en = 0;
    tick();

    // Reset the cycle after a read accept drops the response
    cfg_4x4_mode = 1;
    tick(); tick();
    @(negedge clk);
    chk("pre_rst_mode", mem_in_4x4_mode, 1);
    tick();
    rd_valid = 1; rd_addr = 4'd3;
    @(negedge clk);
    chk("rst_rd_accept", rd_ready, 1);
    tick();
    rd_valid = 0; rst = 1;
    @(negedge clk);
    chk("rst_drop_rdv", rd_data_valid, 0);
    tick();
    rst = 0; cfg_4x4_mode = 0;
    @(negedge clk);
    chk("post_rst_rdv", rd_data_valid, 0);
    chk("post_rst_mode", mem_in_4x4_mode, 0);
    chk("post_rst_pd", mem_power_down, 0);
    chk("post_rst_cs", mem_chip_select, 0);
    tick();

    // Reset while asleep releases power_down next cycle
    go_to_sleep();
    rst = 1; cfg_sleep_en = 0;
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_sleep_pd", mem_power_down, 0);
    chk("rst_sleep_asleep", asleep, 0);
    tick(); tick();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
